// File: rtl/note_timer.sv
// Minibeat/beat timebase plus a single-note duration timer with a valid/ready note intake.
// Optional NOTE_TIMER_GAP_EN adds a one-minibeat silent gap after each note.
`timescale 1ns/1ps
module note_timer #(
   parameter int unsigned CLK_PER_MINIBEAT = 520833
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       play_enable,
   input  logic       note_valid,
   input  logic [5:0] note_duration,
   output logic       note_ready,
   output logic [5:0] duration,
   output logic       minibeat,
   output logic       beat,
   output logic       note_start,
   output logic       note_active,
   output logic       note_done
);

   localparam logic [19:0] PRESC_LAST = 20'(CLK_PER_MINIBEAT - 1);

   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

   state_t      state;
   logic [1:0]  rst_sync;
   logic        rst_n;
   logic [19:0] presc;
   logic [1:0]  mb_cnt;
   logic [7:0]  countdown;
   logic        tick;
   logic        accept;
   logic [5:0]  dur_eff;

   // Assert asynchronously, release two edges later so the timebase starts on a clean edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) rst_sync <= 2'b00;
      else        rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

   assign tick       = play_enable && (presc == PRESC_LAST);
   assign note_ready = (state == IDLE);
   assign accept     = note_valid && note_ready;
   assign dur_eff    = (note_duration < 6'd4) ? 6'd4 : note_duration;

   // Free-running timebase; frozen (not reset) while paused so no tick is lost or repeated.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc    <= '0;
         mb_cnt   <= '0;
         minibeat <= 1'b0;
         beat     <= 1'b0;
      end else begin
         minibeat <= tick;
         beat     <= tick && (mb_cnt == 2'd3);
         if (play_enable) presc <= tick ? '0 : presc + 20'd1;
         if (tick)        mb_cnt <= mb_cnt + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         countdown   <= '0;
         duration    <= '0;
         note_start  <= 1'b0;
         note_active <= 1'b0;
         note_done   <= 1'b0;
      end else begin
         note_start <= 1'b0;
         note_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  duration    <= dur_eff;
                  countdown   <= {dur_eff, 2'b00};
                  note_start  <= 1'b1;
                  note_active <= 1'b1;
                  state       <= PLAY;
               end
            end
            PLAY: begin
               // note_done is visible during the final minibeat; the note ends on the edge after it.
               if (note_done) begin
                  note_active <= 1'b0;
`ifdef NOTE_TIMER_GAP_EN
                  state       <= GAP;
`else
                  state       <= IDLE;
`endif
               end else if (tick) begin
                  countdown <= countdown - 8'd1;
                  if (countdown == 8'd1) note_done <= 1'b1;
               end
            end
            GAP: begin
               if (tick) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_note_timer.sv
// Scoreboard bench for note_timer: expected notes queued at handshake, checked at note_start/note_done.
`timescale 1ns/1ps
module tb_note_timer;
   localparam int CLK = 4;
`ifdef NOTE_TIMER_GAP_EN
   localparam int RDY_AFTER = 0;
`else
   localparam int RDY_AFTER = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       play_enable = 1'b0;
   logic       note_valid = 1'b0;
   logic [5:0] note_duration = '0;
   logic       note_ready;
   logic [5:0] duration;
   logic       minibeat, beat, note_start, note_active, note_done;

   note_timer #(.CLK_PER_MINIBEAT(CLK)) dut (
      .clk(clk), .reset(reset), .play_enable(play_enable), .note_valid(note_valid),
      .note_duration(note_duration), .note_ready(note_ready), .duration(duration),
      .minibeat(minibeat), .beat(beat), .note_start(note_start),
      .note_active(note_active), .note_done(note_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0] dur;
      int         nmb;
      int         lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errs = 0;
   int   n_start = 0;
   int   n_done = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic logic [5:0] eff_dur(input logic [5:0] d);
      return (d < 6'd4) ? 6'd4 : d;
   endfunction

   // Monitor: samples on the falling edge, away from the active edge.
   int en_clks = 0, mb_since_beat = 0, lat = 0, mbcnt = 0;
   bit first_mb = 1, first_beat = 1, in_note = 0, post_done = 0;
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         sb_q.delete();
         en_clks = 0; mb_since_beat = 0;
         first_mb = 1; first_beat = 1; in_note = 0; post_done = 0;
         chk("rst_no_done", note_done, 0);
      end else begin
         if (post_done) begin
            chk("ready_after_done", note_ready, RDY_AFTER);
            chk("inactive_after_done", note_active, 0);
            post_done = 0;
         end
         if (in_note) begin
            lat++;
            if (minibeat) mbcnt++;
         end
         if (minibeat) begin
            if (first_mb) chk("mb_first_full", int'(en_clks >= CLK), 1);
            else          chk("mb_period", en_clks, CLK);
            first_mb = 0; en_clks = 0; mb_since_beat++;
         end
         if (beat) begin
            chk("beat_on_mb", minibeat, 1);
            if (!first_beat) chk("beat_period", mb_since_beat, 4);
            first_beat = 0; mb_since_beat = 0;
         end
         if (note_start) begin
            n_start++;
            chk("start_expected", int'(sb_q.size() > 0), 1);
            chk("start_active", note_active, 1);
            chk("start_not_ready", note_ready, 0);
            if (sb_q.size() > 0) chk("start_duration", duration, sb_q[0].dur);
            in_note = 1; lat = 0; mbcnt = 0;
         end
         if (note_done) begin
            n_done++;
            chk("done_in_note", in_note, 1);
            chk("done_on_mb", minibeat, 1);
            if (sb_q.size() > 0) begin
               mon_e = sb_q.pop_front();
               chk("done_minibeats", mbcnt, mon_e.nmb);
               if (mon_e.lat >= 0) chk("done_latency", lat, mon_e.lat);
               chk("done_duration", duration, mon_e.dur);
            end else begin
               chk("done_expected", 0, 1);
            end
            in_note = 0; post_done = 1;
         end
         if (play_enable) en_clks++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic align_mb();
      int k = 0;
      do begin step(); k++; end while (!minibeat && k < 4 * CLK);
      if (!minibeat) chk("align_timeout", 0, 1);
   endtask

   task automatic wait_done(input int target, input int budget);
      int k = 0;
      while (n_done < target && k < budget) begin step(); k++; end
      chk("done_timeout", int'(n_done >= target), 1);
   endtask

   // Send one note phase-aligned one clock after a minibeat, optionally pausing mid-note.
   task automatic send(input logic [5:0] d, input int pause);
      logic [5:0] de;
      int nmb, target;
      de = eff_dur(d);
      nmb = int'(de) * 4;
      align_mb();
      chk("ready_before_send", note_ready, 1);
      note_valid = 1'b1; note_duration = d;
      sb_q.push_back('{de, nmb, CLK * nmb - 1 + pause});
      target = n_done + 1;
      step();
      note_valid = 1'b0; note_duration = 6'($urandom);
      if (pause > 0) begin
         repeat (3 * CLK + 1) step();
         play_enable = 1'b0;
         repeat (pause) step();
         play_enable = 1'b1;
      end
      wait_done(target, CLK * nmb + pause + 20);
   endtask

   initial begin
      int pushed, k, m, target;
      play_enable = 1'b1;
      repeat (3) step();
      chk("rst_ready", note_ready, 1);
      chk("rst_active", note_active, 0);
      chk("rst_duration", duration, 0);
      chk("rst_minibeat", minibeat, 0);
      reset = 1'b1;
      #1 chk("rel_ready", note_ready, 1);

      repeat (40) step();
      send(6'd6, 0);
      send(6'd1, 0);
      send(6'd6, 10);

      // note_valid held through PLAY; the mid-note duration change must not leak in.
      note_valid = 1'b1; note_duration = 6'd2; pushed = 0; k = 0; target = n_done + 2;
      while (pushed < 2 && k < 500) begin
         if (note_ready) begin
            sb_q.push_back('{eff_dur(note_duration), int'(eff_dur(note_duration)) * 4, -1});
            pushed++;
         end
         step(); k++;
         if (pushed == 1) note_duration = 6'd9;
         else if (pushed == 2) note_valid = 1'b0;
      end
      note_valid = 1'b0;
      wait_done(target, 400);
      chk("held_starts", n_start, 5);

      send(6'd0, 0);
      send(6'd63, 0);

      // Abort a 16-minibeat note at its 7th minibeat.
      align_mb();
      note_valid = 1'b1; note_duration = 6'd4;
      sb_q.push_back('{6'd4, 16, 16 * CLK - 1});
      step();
      note_valid = 1'b0;
      m = 0; k = 0;
      while (m < 7 && k < 200) begin step(); k++; if (minibeat) m++; end
      chk("abort_reached_mb7", m, 7);
      target = n_done;
      #1 reset = 1'b0;
      #1;
      chk("abort_active", note_active, 0);
      chk("abort_minibeat", minibeat, 0);
      chk("abort_beat", beat, 0);
      chk("abort_start", note_start, 0);
      chk("abort_done", note_done, 0);
      chk("abort_duration", duration, 0);
      chk("abort_ready", note_ready, 1);
      repeat (3) step();
      reset = 1'b1;
      #1 chk("abort_rel_ready", note_ready, 1);
      repeat (4) step();
      chk("abort_no_done", n_done, target);

      send(6'd5, 0);
      repeat (5) step();
      chk("sb_empty", sb_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
